instruction_encode: RTL and testbench
=====================================

INSTRUCTION_ENCODE -- requirements
Module: instruction_encode

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: first write address after reset or clear.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 clear  in  1  synchronous flush of buffer, address and error state.
REQ-005 in_valid  in  1  field bundle valid.
REQ-006 in_ready  out  1  block can accept a bundle this cycle.
REQ-007 opcode  in  7, rd  in  5, funct3  in  3, rs1  in  5, rs2  in  5, funct7  in  7  RV32I instruction fields.
REQ-008 imm  in  32  full-width immediate, unshuffled.
REQ-009 out_valid  out  1  encoded word available.
REQ-010 out_ready  in  1  consumer (instruction-memory writer) takes the word.
REQ-011 out_data  out  32  encoded instruction; out_addr  out  32  target byte address.
REQ-012 err_illegal  out  1  sticky: unsupported opcode seen; err_misalign  out  1  sticky: B/J imm[0]=1 seen.
REQ-013 drop_cnt  out  8  count of dropped bundles, saturating at 255.

Function
REQ-014 Accept occurs when in_valid and in_ready are both 1 on a rising edge.
REQ-015 in_ready is 1 when the 2-entry output buffer holds fewer than 2 words, independent of out_ready.
REQ-016 R (0110011): out_data = {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-017 I (0000011, 1100111, and 0010011 with funct3 not 001/101): out_data = {imm[11:0], rs1, funct3, rd, opcode}.
REQ-018 Shift-immediate (0010011 with funct3 001/101): out_data = {funct7, imm[4:0], rs1, funct3, rd, opcode}.
REQ-019 S (0100011): out_data = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-020 B (1100011): out_data = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-021 U (0110111, 0010111): out_data = {imm[31:12], rd, opcode}.
REQ-022 J (1101111): out_data = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-023 Unused immediate bits are ignored; no range check beyond REQ-025.
REQ-024 Accepted bundle with any other opcode: consumed, not buffered, err_illegal set, drop_cnt incremented, address unchanged.
REQ-025 Accepted B/J bundle with imm[0]=1: consumed, not buffered, err_misalign set, drop_cnt incremented, address unchanged.
REQ-026 Legal accepted bundle is written to the buffer tail with the current write address; the address then advances by 4, wrapping modulo 2^32.
REQ-027 Latency: a legal bundle accepted at edge N is visible on out_valid/out_data/out_addr after edge N (1 cycle); the head is registered, with no combinational path from inputs to outputs.
REQ-028 Buffer is FIFO ordered; the head pops when out_valid and out_ready are both 1.
REQ-029 Push and pop in the same cycle: the count is unchanged and order is preserved.
REQ-030 out_data/out_addr hold stable while out_valid=1 and out_ready=0.
REQ-031 clear=1: buffer empties, address returns to BASE_ADDR, error flags and drop_cnt zero; any same-cycle accept is discarded; in_ready stays 1 during clear.

Reset
REQ-032 rst_n low asynchronously forces: buffer empty, out_valid=0, out_data=0, out_addr=BASE_ADDR, address=BASE_ADDR, err_illegal=0, err_misalign=0, drop_cnt=0.
REQ-033 While rst_n is low, in_ready=0; it becomes 1 on the first edge after release.
REQ-034 Reset mid-transfer discards all buffered words; no partial word is ever emitted.

Verification
REQ-035 ADD x3,x1,x2 (op 0110011, rd 3, rs1 1, rs2 2, f3 0, f7 0) -> out_data 32'h002081B3, out_addr BASE_ADDR, one cycle later.
REQ-036 ADDI x1,x0,-1 (imm 32'hFFFFFFFF), then BEQ x1,x2,+8 (imm 8) -> 32'hFFF00093 at BASE, then 32'h00208463 at BASE+4.
REQ-037 JAL x1,+2048 (imm 32'h800) -> 32'h001000EF; SRAI x5,x5,3 (f7 0100000) -> 32'h4032D293.
REQ-038 out_ready=0 with 3 back-to-back legal bundles -> in_ready drops after 2; raising out_ready drains BASE, BASE+4, then the third at BASE+8, in order.
REQ-039 opcode 7'h7F, then BEQ with imm 3 -> no output, err_illegal=1, err_misalign=1, drop_cnt=2, next legal word at BASE.
REQ-040 rst_n low while 2 words are buffered -> out_valid=0 immediately (asynchronously); after release the first word goes to BASE_ADDR.

Source files
------------

// File: rtl/instruction_encode.sv
// RV32I field-bundle encoder. Each bundle is packed into a 32-bit
// instruction word. Legal words are queued in a 2-entry FIFO together
// with a byte address that advances by 4 per word. Illegal and
// misaligned bundles are counted and flagged, and nothing is queued.
module instruction_encode #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic        err_illegal,
    output logic        err_misalign,
    output logic [7:0]  drop_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Slot 0 is the head and drives the outputs directly. Slot 1 is the tail.
    logic [31:0] r_data [2];
    logic [31:0] r_addr [2];
    logic [1:0]  r_count;
    logic [31:0] r_wr_addr;
    logic        r_live;
    logic        r_err_ill;
    logic        r_err_mis;
    logic [7:0]  r_drop;

    logic [31:0] w_enc;
    logic        w_legal;
    logic        w_misalign;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    // Classify the opcode and assemble the instruction word.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_enc      = 32'd0;
        w_legal    = 1'b0;
        w_misalign = 1'b0;
        unique case (opcode)
            OP_R: begin
                w_enc   = {funct7, rs2, rs1, funct3, rd, opcode};
                w_legal = 1'b1;
            end
            OP_LOAD, OP_JALR: begin
                w_enc   = {imm[11:0], rs1, funct3, rd, opcode};
                w_legal = 1'b1;
            end
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    w_enc = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                else
                    w_enc = {imm[11:0], rs1, funct3, rd, opcode};
                w_legal = 1'b1;
            end
            OP_STORE: begin
                w_enc   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                w_legal = 1'b1;
            end
            OP_BRANCH: begin
                w_enc      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                w_misalign = imm[0];
                w_legal    = ~imm[0];
            end
            OP_LUI, OP_AUIPC: begin
                w_enc   = {imm[31:12], rd, opcode};
                w_legal = 1'b1;
            end
            OP_JAL: begin
                w_enc      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                w_misalign = imm[0];
                w_legal    = ~imm[0];
            end
            default: ;
        endcase
    end

    // Handshake decode. During a clear, in_ready stays high even when the buffer is full.
    assign in_ready  = r_live & ((r_count != 2'd2) | clear);
    assign w_accept  = in_valid & in_ready;
    assign w_push    = w_accept & w_legal & ~clear;
    assign w_pop     = (r_count != 2'd0) & out_ready;

    assign out_valid    = (r_count != 2'd0);
    assign out_data     = r_data[0];
    assign out_addr     = r_addr[0];
    assign err_illegal  = r_err_ill;
    assign err_misalign = r_err_mis;
    assign drop_cnt     = r_drop;

    // FIFO slots, write address, error flags and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two slots are reset explicitly because slot 0 is a visible output (out_data and out_addr).
            r_data[0] <= 32'd0;
            r_data[1] <= 32'd0;
            r_addr[0] <= BASE_ADDR;
            r_addr[1] <= BASE_ADDR;
            r_count   <= 2'd0;
            r_wr_addr <= BASE_ADDR;
            r_live    <= 1'b0;
            r_err_ill <= 1'b0;
            r_err_mis <= 1'b0;
            r_drop    <= 8'd0;
        end else begin
            // NOTE: state updates use non-blocking assignments, so every right-hand side reads the pre-edge values.
            r_live <= 1'b1;
            if (clear) begin
                r_data[0] <= 32'd0;
                r_data[1] <= 32'd0;
                r_addr[0] <= BASE_ADDR;
                r_addr[1] <= BASE_ADDR;
                r_count   <= 2'd0;
                r_wr_addr <= BASE_ADDR;
                r_err_ill <= 1'b0;
                r_err_mis <= 1'b0;
                r_drop    <= 8'd0;
            end else begin
                if (w_accept && !w_legal) begin
                    if (w_misalign) r_err_mis <= 1'b1;
                    else            r_err_ill <= 1'b1;
                    if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
                end
                if (w_push) r_wr_addr <= r_wr_addr + 32'd4;
                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_count == 2'd0) begin
                            r_data[0] <= w_enc;
                            r_addr[0] <= r_wr_addr;
                        end else begin
                            r_data[1] <= w_enc;
                            r_addr[1] <= r_wr_addr;
                        end
                        r_count <= r_count + 2'd1;
                    end
                    2'b01: begin
                        r_data[0] <= r_data[1];
                        r_addr[0] <= r_addr[1];
                        r_count   <= r_count - 2'd1;
                    end
                    2'b11: begin
                        if (r_count == 2'd1) begin
                            r_data[0] <= w_enc;
                            r_addr[0] <= r_wr_addr;
                        end else begin
                            r_data[0] <= r_data[1];
                            r_addr[0] <= r_addr[1];
                            r_data[1] <= w_enc;
                            r_addr[1] <= r_wr_addr;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_encode.sv
// Self-checking bench for instruction_encode. The reference model is a
// queue of expected {word, address} entries. The compare process checks
// the DUT against this model on every falling edge. The directed tests
// also check known encodings given as literal constants.
module tb_instruction_encode;

    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
    } bundle_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic        err_illegal;
    logic        err_misalign;
    logic [7:0]  drop_cnt;
    bundle_t     b;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    entry_t      q[$];
    logic [31:0] m_addr;
    bit          m_live;
    bit          m_ill;
    bit          m_mis;
    int          m_drop;

    instruction_encode #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(b.op), .rd(b.rd), .funct3(b.f3), .rs1(b.rs1), .rs2(b.rs2),
        .funct7(b.f7), .imm(b.imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .err_illegal(err_illegal), .err_misalign(err_misalign),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Return value: 0 = legal, 1 = illegal opcode, 2 = misaligned B/J target.
    function automatic int ref_enc(input bundle_t x, output logic [31:0] w);
        logic [31:0] i;
        i = x.imm;
        w = 32'd0;
        case (x.op)
            7'h33: w = 32'(x.f7) << 25 | 32'(x.rs2) << 20 | 32'(x.rs1) << 15
                     | 32'(x.f3) << 12 | 32'(x.rd) << 7 | 32'(x.op);
            7'h03, 7'h67: w = (i & 32'hFFF) << 20 | 32'(x.rs1) << 15
                     | 32'(x.f3) << 12 | 32'(x.rd) << 7 | 32'(x.op);
            7'h13: begin
                if (x.f3 == 3'd1 || x.f3 == 3'd5)
                    w = 32'(x.f7) << 25 | (i & 32'h1F) << 20;
                else
                    w = (i & 32'hFFF) << 20;
                w = w | 32'(x.rs1) << 15 | 32'(x.f3) << 12 | 32'(x.rd) << 7 | 32'(x.op);
            end
            7'h23: w = ((i >> 5) & 32'h7F) << 25 | 32'(x.rs2) << 20 | 32'(x.rs1) << 15
                     | 32'(x.f3) << 12 | (i & 32'h1F) << 7 | 32'(x.op);
            7'h63: begin
                if (i[0]) return 2;
                w = ((i >> 12) & 1) << 31 | ((i >> 5) & 32'h3F) << 25
                  | 32'(x.rs2) << 20 | 32'(x.rs1) << 15 | 32'(x.f3) << 12
                  | ((i >> 1) & 32'hF) << 8 | ((i >> 11) & 1) << 7 | 32'(x.op);
            end
            7'h37, 7'h17: w = (i & 32'hFFFF_F000) | 32'(x.rd) << 7 | 32'(x.op);
            7'h6F: begin
                if (i[0]) return 2;
                w = ((i >> 20) & 1) << 31 | ((i >> 1) & 32'h3FF) << 21
                  | ((i >> 11) & 1) << 20 | ((i >> 12) & 32'hFF) << 12
                  | 32'(x.rd) << 7 | 32'(x.op);
            end
            default: return 1;
        endcase
        return 0;
    endfunction

    function automatic bit m_ready();
        return m_live && (q.size() < 2 || clear);
    endfunction

    task automatic model_reset();
        q.delete();
        m_addr = BASE;
        m_live = 0;
        m_ill  = 0;
        m_mis  = 0;
        m_drop = 0;
    endtask

    // Apply one rising edge to the model, using the inputs held across that edge.
    task automatic model_step();
        logic [31:0] w;
        int          kind;
        bit          rdy;
        bit          pop;
        if (!rst_n) return;
        rdy = m_ready();
        pop = (q.size() != 0) && out_ready;
        if (clear) begin
            q.delete();
            m_addr = BASE;
            m_ill  = 0;
            m_mis  = 0;
            m_drop = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (in_valid && rdy) begin
                kind = ref_enc(b, w);
                if (kind == 0) begin
                    q.push_back('{data: w, addr: m_addr});
                    m_addr = m_addr + 4;
                end else begin
                    if (kind == 1) m_ill = 1; else m_mis = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
        m_live = 1;
    endtask

    // Compare process: checks the DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(m_ready()));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_data", out_data, q[0].data);
            check("out_addr", out_addr, q[0].addr);
        end
        check("err_illegal", 32'(err_illegal), 32'(m_ill));
        check("err_misalign", 32'(err_misalign), 32'(m_mis));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic bundle_t mk(input logic [6:0] op, input logic [4:0] rd_i,
                                   input logic [2:0] f3, input logic [4:0] r1,
                                   input logic [4:0] r2, input logic [6:0] f7,
                                   input logic [31:0] im);
        return '{op: op, rd: rd_i, f3: f3, rs1: r1, rs2: r2, f7: f7, imm: im};
    endfunction

    task automatic send(input bundle_t x);
        b = x;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    bundle_t add_b;
    logic [6:0] ops [11] = '{7'h33, 7'h03, 7'h67, 7'h13, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0B};

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; b = '0;
        model_reset();
        add_b = mk(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);

        // Reset state
        @(posedge clk); #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst out_addr", out_addr, BASE);
        check("rst in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        cycle();
        check("in_ready after release", 32'(in_ready), 32'd1);

        // ADD x3,x1,x2
        out_ready = 1'b1;
        send(add_b);
        check("ADD data", out_data, 32'h002081B3);
        check("ADD addr", out_addr, BASE);
        check("ADD valid", 32'(out_valid), 32'd1);
        cycle();

        // ADDI x1,x0,-1 then BEQ x1,x2,+8
        do_clear();
        out_ready = 1'b0;
        send(mk(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF));
        check("ADDI data", out_data, 32'hFFF00093);
        check("ADDI addr", out_addr, BASE);
        send(mk(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd8));
        out_ready = 1'b1;
        cycle();
        check("BEQ data", out_data, 32'h00208463);
        check("BEQ addr", out_addr, BASE + 4);
        cycle();

        // JAL x1,+2048 and SRAI x5,x5,3
        send(mk(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h800));
        check("JAL data", out_data, 32'h001000EF);
        send(mk(7'h13, 5'd5, 3'd5, 5'd5, 5'd0, 7'h20, 32'd3));
        check("SRAI data", out_data, 32'h4032D293);
        cycle();

        // Backpressure: three bundles while out_ready=0
        do_clear();
        out_ready = 1'b0;
        send(add_b);
        add_b.rd = 5'd4;
        send(add_b);
        check("full in_ready", 32'(in_ready), 32'd0);
        add_b.rd = 5'd5;
        b = add_b; in_valid = 1'b1; out_ready = 1'b1;
        check("drain 1 addr", out_addr, BASE);
        cycle();
        check("drain 2 addr", out_addr, BASE + 4);
        cycle();
        in_valid = 1'b0;
        check("drain 3 addr", out_addr, BASE + 8);
        check("drain 3 data", out_data, 32'h002082B3);
        cycle();

        // Illegal opcode, misaligned branch, then a legal bundle
        do_clear();
        send(mk(7'h7F, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 32'd0));
        send(mk(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3));
        check("drop no output", 32'(out_valid), 32'd0);
        check("err_illegal set", 32'(err_illegal), 32'd1);
        check("err_misalign set", 32'(err_misalign), 32'd1);
        check("drop_cnt 2", 32'(drop_cnt), 32'd2);
        send(add_b);
        check("after drop addr", out_addr, BASE);
        cycle();

        // Drop counter saturation
        for (int i = 0; i < 260; i++) send(mk(7'h7F, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0));
        check("drop_cnt saturates", 32'(drop_cnt), 32'd255);

        // Asynchronous reset while two words are buffered
        do_clear();
        out_ready = 1'b0;
        send(add_b);
        send(add_b);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst in_ready", 32'(in_ready), 32'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        out_ready = 1'b1;
        send(add_b);
        check("post-reset addr", out_addr, BASE);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            b.op   = ops[$urandom_range(0, 10)];
            b.rd   = 5'($urandom);
            b.f3   = 3'($urandom);
            b.rs1  = 5'($urandom);
            b.rs2  = 5'($urandom);
            b.f7   = 7'($urandom);
            b.imm  = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 60) == 0);
            cycle();
        end
        in_valid = 1'b0;
        clear = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
